if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
Instruction-fetch front end that sits upstream of the IF/ID pipeline register. It owns the PC and issues in-order requests to instruction memory over a valid/ready request channel and a valid-only response channel. It buffers returned instructions and presents them, with their fetch addresses, to IF/ID. It honours IF/ID write-enable (stall) and branch redirect (flush), and discards stale in-flight responses after a redirect.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
PC_STEP, 4, byte increment per sequential fetch.
DEPTH, 2, max (outstanding requests + buffered instructions); fixed power of two ≥2.

Ports:
clk  in  1  rising-edge clock.
reset_n  in  1  asynchronous, active-low reset.
if_id_write  in  1  1 = IF/ID accepts the presented instruction this cycle; 0 = stall.
redirect  in  1  flush/branch-taken pulse; same cycle IF/ID flush is asserted.
redirect_addr  in  64  new PC on redirect.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  64  fetch byte address.
imem_resp_valid  in  1  one in-order response word valid.
imem_resp_data  in  32  instruction word.
inst_valid  out  1  Instruction/Inst_Addr hold a live instruction.
Instruction  out  32  instruction to IF/ID.
Inst_Addr  out  64  address of Instruction.

Behaviour:
- Reset (reset_n=0, async): pc=RESET_PC; outstanding=0; drop_cnt=0; buffer empty; inst_valid=0, Instruction=32'h0, Inst_Addr=64'h0; imem_req_valid=0 while in reset.
- Credit: issue allowed iff outstanding + buf_count < DEPTH, counting this cycle's pop/push.
- Request: imem_req_valid = credit & ~redirect; imem_req_addr = pc. On valid&ready: pc <= pc+PC_STEP (64-bit wrap at 2^64), push pc into address tag queue, outstanding+1. No request is withdrawn once valid unless redirect asserts.
- Response: imem_resp_valid with drop_cnt>0 → discard word, drop_cnt-1, outstanding-1. Otherwise pop tag queue; push {tag, data} into output buffer, outstanding-1. A response with outstanding=0 is a protocol error; assertion in sim, ignored in RTL.
- Output: registered head of buffer. Word received in cycle N is visible in cycle N+1 at the earliest. Empty buffer → inst_valid=0, Instruction=0, Inst_Addr=0.
- Consume: inst_valid & if_id_write pops the head; next entry (if any) is presented the following cycle. if_id_write=0 holds the outputs stable.
- Redirect (highest priority): next cycle pc=redirect_addr; buffer cleared; inst_valid=0; drop_cnt <= outstanding, adjusted for any response and handshake in the same cycle so that every in-flight word is dropped; no request is issued that cycle. A response arriving in the redirect cycle is discarded. First request to redirect_addr issues the cycle after redirect if credit exists.
- Back-to-back redirects: the latest one wins. drop_cnt accumulates correctly and never underflows.
- Simultaneous push and pop on the buffer in one cycle is allowed; count is unchanged.
- Throughput: with 1-cycle memory latency and no stalls, sustains 1 instruction/cycle after a 2-cycle startup.

Test Plan:
- Reset release, RESET_PC=0, req_ready=1, 1-cycle response latency, if_id_write=1 → req addrs 0,4,8,...; Inst_Addr sequence 0,4,8 with matching data, one per cycle from cycle 3.
- if_id_write=0 for 5 cycles mid-stream at Inst_Addr=8 → outputs held at 8; at most DEPTH requests in flight; no word lost or duplicated after release (next Inst_Addr=12).
- req_ready=0 for 4 cycles → imem_req_valid held, imem_req_addr constant; pc advances only on handshake.
- Redirect to 64'h100 with 2 outstanding (latency 3) → both stale responses dropped; first Inst_Addr presented = 0x100 with its data, inst_valid=0 until then.
- Redirect in the same cycle as imem_resp_valid and as a would-be handshake → no request issued, response dropped, no stale instruction ever presented.
- reset_n asserted asynchronously mid-stream with a full buffer → all outputs zero immediately; late memory responses after re-reset are not required to be handled (bench quiesces memory).

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order imem requests, buffers returned words for IF/ID.
// Latency: a response word accepted in cycle N is presented in cycle N+1; redirect takes effect the next cycle.
// Backpressure: requests are credit-limited to DEPTH (in flight + buffered); if_id_write=0 holds the presented word.

module if_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_rdy)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
endmodule

module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          PC_STEP  = 4,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_id_write,
    input  logic        redirect,
    input  logic [63:0] redirect_addr,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] Instruction,
    output logic [63:0] Inst_Addr
);
    localparam int             AW        = $clog2(DEPTH);
    localparam int             CW        = AW + 1;
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [CW:0]    DEPTH_LIM = (CW+1)'(DEPTH);

    logic [63:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_cnt;
    logic [63:0]   ent_addr [DEPTH];
    logic [31:0]   ent_data [DEPTH];
    logic [63:0]   tag_addr;

    logic          req_hs;
    logic          resp_any;
    logic          resp_drop;
    logic          resp_live;
    logic          buf_pop;
    logic          credit;
    logic [CW:0]   occ_eff;
    logic [CW-1:0] wr_idx;

    assign resp_any  = imem_resp_valid && (outstanding != '0);
    assign resp_drop = resp_any && !redirect && (drop_cnt != '0);
    assign resp_live = resp_any && !redirect && (drop_cnt == '0);
    assign buf_pop   = inst_valid && if_id_write && !redirect;

    // A live response moves a slot from in-flight to buffered, so only pops and drops free credit.
    always_comb begin
        occ_eff = {1'b0, outstanding} + {1'b0, buf_cnt}
                - {{CW{1'b0}}, buf_pop} - {{CW{1'b0}}, resp_drop};
        credit  = (occ_eff < DEPTH_LIM);
    end

    assign imem_req_valid = reset_n && credit && !redirect;
    assign imem_req_addr  = pc;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign wr_idx         = buf_cnt - (buf_pop ? CNT_ONE : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (redirect)    pc <= redirect_addr;
            else if (req_hs) pc <= pc + 64'(PC_STEP);

            case ({req_hs, resp_any})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase

            // Everything still in flight after a redirect belongs to the old stream.
            if (redirect)       drop_cnt <= outstanding - (resp_any ? CNT_ONE : '0);
            else if (resp_drop) drop_cnt <= drop_cnt - CNT_ONE;
        end
    end

    // Shift buffer: entry 0 is the presented head, unused entries are kept zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else if (redirect) begin
            buf_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (buf_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    ent_addr[i] <= ent_addr[i+1];
                    ent_data[i] <= ent_data[i+1];
                end
                ent_addr[DEPTH-1] <= '0;
                ent_data[DEPTH-1] <= '0;
            end
            if (resp_live) begin
                ent_addr[wr_idx[AW-1:0]] <= tag_addr;
                ent_data[wr_idx[AW-1:0]] <= imem_resp_data;
            end
            case ({resp_live, buf_pop})
                2'b10:   buf_cnt <= buf_cnt + CNT_ONE;
                2'b01:   buf_cnt <= buf_cnt - CNT_ONE;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    if_fetch_fifo #(.W(64), .DEPTH(DEPTH)) u_tag_q (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (redirect),
        .push_vld (req_hs),
        .push_dat (pc),
        .pop_rdy  (resp_live),
        .pop_dat  (tag_addr)
    );

    assign inst_valid  = (buf_cnt != '0);
    assign Instruction = ent_data[0];
    assign Inst_Addr   = ent_addr[0];

    resp_has_owner: assert property (@(posedge clk) disable iff (!reset_n)
        imem_resp_valid |-> (outstanding != '0));
endmodule
